// File: rtl/core_bank_interface_pkg.sv
// Shared TitanComms definitions: host instruction codes, status word layout
// and the per-core run-control state encoding.
package core_bank_interface_pkg;

    typedef enum logic [7:0] {
        NOP   = 8'h00,
        WRITE = 8'h01,
        READ  = 8'h02
    } instructions;

    localparam int STATUS_BUSY_BIT  = 0;
    localparam int STATUS_VALID_BIT = 1;
    localparam int STATUS_ERROR_BIT = 2;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } core_state_t;

endpackage

// File: rtl/core_bank_interface_core_channel.sv
// One compute core's host-facing slice: parameter registers, start/done FSM,
// result capture and status word, addressed by a core-local offset.
//
// state | meaning
// IDLE  | never started since reset, parameters writable
// RUN   | core running, parameter writes and restarts rejected
// DONE  | results captured, parameters writable, may be restarted
module core_channel
    import core_bank_interface_pkg::*;
#(
    parameter int PARAMS     = 2,
    parameter int RESULTS    = 1,
    parameter int DATA_WIDTH = 32,
    parameter int OFF_W      = 2,
    parameter bit AUTO_START = 1'b0
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          wr_en,
    input  logic [OFF_W-1:0]              offset,
    input  logic [DATA_WIDTH-1:0]         value,
    input  logic                          core_done,
    input  logic [RESULTS*DATA_WIDTH-1:0] core_results,
    output logic [PARAMS*DATA_WIDTH-1:0]  params,
    output logic                          core_start,
    output logic [DATA_WIDTH-1:0]         rdata
);
    localparam logic [OFF_W-1:0] STATUS_OFF = OFF_W'(PARAMS + RESULTS);
    localparam logic [OFF_W-1:0] LAST_PARAM = OFF_W'(PARAMS - 1);

    core_state_t state, state_next;
    logic [DATA_WIDTH-1:0] param_q  [PARAMS];
    logic [DATA_WIDTH-1:0] result_q [RESULTS];
    logic result_valid, error;
    logic busy, status_wr, param_wr, start_req, err_set, err_clr, capture;

    always_comb begin
        busy       = (state == RUN);
        status_wr  = wr_en && (offset == STATUS_OFF);
        param_wr   = wr_en && (offset < OFF_W'(PARAMS));
        start_req  = (status_wr && value[0]) || (AUTO_START && wr_en && (offset == LAST_PARAM));
        err_set    = busy && (param_wr || start_req);
        err_clr    = status_wr && value[STATUS_ERROR_BIT];
        // core_done is masked while the start pulse is still out
        capture    = busy && core_done && !core_start;
        state_next = state;
        case (state)
            IDLE, DONE: if (start_req) state_next = RUN;
            RUN:        if (capture)   state_next = DONE;
            default:    state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= IDLE;
            core_start   <= 1'b0;
            result_valid <= 1'b0;
            error        <= 1'b0;
            for (int i = 0; i < PARAMS; i++)  param_q[i]  <= '0;
            for (int i = 0; i < RESULTS; i++) result_q[i] <= '0;
        end else begin
            state      <= state_next;
            core_start <= !busy && start_req;
            if (err_set)      error <= 1'b1;
            else if (err_clr) error <= 1'b0;
            if (!busy && start_req) result_valid <= 1'b0;
            else if (capture)       result_valid <= 1'b1;
            if (capture)
                for (int i = 0; i < RESULTS; i++)
                    result_q[i] <= core_results[i*DATA_WIDTH +: DATA_WIDTH];
            if (param_wr && !busy)
                for (int i = 0; i < PARAMS; i++)
                    if (offset == OFF_W'(i)) param_q[i] <= value;
        end
    end

    always_comb begin
        params = '0;
        for (int i = 0; i < PARAMS; i++) params[i*DATA_WIDTH +: DATA_WIDTH] = param_q[i];
    end

    always_comb begin
        rdata = '0;
        for (int i = 0; i < PARAMS; i++)
            if (offset == OFF_W'(i)) rdata = param_q[i];
        for (int i = 0; i < RESULTS; i++)
            if (offset == OFF_W'(PARAMS + i)) rdata = result_q[i];
        if (offset == STATUS_OFF) begin
            rdata[STATUS_BUSY_BIT]  = busy;
            rdata[STATUS_VALID_BIT] = result_valid;
            rdata[STATUS_ERROR_BIT] = error;
        end
    end

endmodule

// File: rtl/core_bank_interface.sv
// Multi-core parameter interface: decodes host NOP/WRITE/READ accesses onto a
// bank of core channels and returns registered read data.
module core_bank_interface
    import core_bank_interface_pkg::*;
#(
    parameter int NUM_CORES        = 2,
    parameter int PARAMS_PER_CORE  = 2,
    parameter int RESULTS_PER_CORE = 1,
    parameter int DATA_WIDTH       = 32,
    parameter int ADDR_WIDTH       = 24,
    parameter int START_ADDRESS    = 0,
    parameter int CORE_STRIDE      = 4,
    parameter bit AUTO_START       = 1'b0
) (
    input  logic                                             clock,
    input  logic                                             reset,
    input  logic [7:0]                                       instruction,
    input  logic [ADDR_WIDTH-1:0]                            address,
    input  logic [DATA_WIDTH-1:0]                            value,
    output logic [DATA_WIDTH-1:0]                            output_value,
    output logic                                             in_range,
    output logic [NUM_CORES*PARAMS_PER_CORE*DATA_WIDTH-1:0]  core_params,
    output logic [NUM_CORES-1:0]                             core_start,
    input  logic [NUM_CORES-1:0]                             core_done,
    input  logic [NUM_CORES*RESULTS_PER_CORE*DATA_WIDTH-1:0] core_results
);
    localparam int OFF_W  = (CORE_STRIDE > 1) ? $clog2(CORE_STRIDE) : 1;
    localparam int PBITS  = PARAMS_PER_CORE * DATA_WIDTH;
    localparam int RBITS  = RESULTS_PER_CORE * DATA_WIDTH;

    if (CORE_STRIDE < PARAMS_PER_CORE + RESULTS_PER_CORE + 1) begin : g_bad_stride
        $error("core_bank_interface: CORE_STRIDE too small for params+results+status");
    end

    logic [ADDR_WIDTH-1:0] offset, core_idx;
    logic [OFF_W-1:0]      local_off;
    logic                  hit;
    logic [NUM_CORES-1:0]  ch_wr;
    logic [DATA_WIDTH-1:0] ch_rdata [NUM_CORES];
    logic [DATA_WIDTH-1:0] read_data;

    // Addresses below the base must not wrap into the bank
    always_comb begin
        offset    = address - ADDR_WIDTH'(START_ADDRESS);
        core_idx  = offset / ADDR_WIDTH'(CORE_STRIDE);
        local_off = OFF_W'(offset % ADDR_WIDTH'(CORE_STRIDE));
        hit       = (address >= ADDR_WIDTH'(START_ADDRESS)) && (core_idx < ADDR_WIDTH'(NUM_CORES));
        ch_wr     = '0;
        read_data = '0;
        for (int c = 0; c < NUM_CORES; c++) begin
            if (core_idx == ADDR_WIDTH'(c)) begin
                ch_wr[c]  = hit && (instruction == WRITE);
                read_data = ch_rdata[c];
            end
        end
    end

    for (genvar c = 0; c < NUM_CORES; c++) begin : g_core
        core_channel #(
            .PARAMS     (PARAMS_PER_CORE),
            .RESULTS    (RESULTS_PER_CORE),
            .DATA_WIDTH (DATA_WIDTH),
            .OFF_W      (OFF_W),
            .AUTO_START (AUTO_START)
        ) u_channel (
            .clock        (clock),
            .reset        (reset),
            .wr_en        (ch_wr[c]),
            .offset       (local_off),
            .value        (value),
            .core_done    (core_done[c]),
            .core_results (core_results[c*RBITS +: RBITS]),
            .params       (core_params[c*PBITS +: PBITS]),
            .core_start   (core_start[c]),
            .rdata        (ch_rdata[c])
        );
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            output_value <= '0;
            in_range     <= 1'b0;
        end else begin
            in_range <= hit;
            if (instruction == READ && hit) output_value <= read_data;
        end
    end

endmodule

// File: tb/tb_core_bank_interface.sv
// Directed bench for core_bank_interface: a default instance plus an
// AUTO_START=1 instance sharing clock, reset and the address/value bus.
module tb_core_bank_interface;
    import core_bank_interface_pkg::*;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic [7:0]    instruction = 8'h00;
    logic [23:0]   address = '0;
    logic [31:0]   value = '0;
    logic [31:0]   output_value;
    logic          in_range;
    logic [127:0]  core_params;
    logic [1:0]    core_start;
    logic [1:0]    core_done = '0;
    logic [63:0]   core_results = '0;

    logic          auto_phase = 1'b0;
    logic [7:0]    instruction_a;
    logic [31:0]   output_value_a;
    logic          in_range_a;
    logic [127:0]  core_params_a;
    logic [1:0]    core_start_a;
    logic [1:0]    core_done_a = '0;
    logic [63:0]   core_results_a = '0;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    assign instruction_a = auto_phase ? instruction : 8'h00;

    core_bank_interface dut (
        .clock(clock), .reset(reset), .instruction(instruction), .address(address),
        .value(value), .output_value(output_value), .in_range(in_range),
        .core_params(core_params), .core_start(core_start), .core_done(core_done),
        .core_results(core_results)
    );

    core_bank_interface #(.AUTO_START(1'b1)) dut_auto (
        .clock(clock), .reset(reset), .instruction(instruction_a), .address(address),
        .value(value), .output_value(output_value_a), .in_range(in_range_a),
        .core_params(core_params_a), .core_start(core_start_a), .core_done(core_done_a),
        .core_results(core_results_a)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic wr(input logic [23:0] a, input logic [31:0] v);
        instruction = WRITE;
        address     = a;
        value       = v;
        cyc();
        instruction = NOP;
    endtask

    task automatic rd(input logic [23:0] a);
        instruction = READ;
        address     = a;
        cyc();
        instruction = NOP;
    endtask

    initial begin
        cyc();
        cyc();
        chk("rst_out", output_value, 0);
        chk("rst_inr", in_range, 0);
        chk("rst_start", core_start, 0);
        chk("rst_params", core_params, 0);
        reset = 1'b0;

        // parameter writes and readback
        wr(24'd0, 32'd7);
        chk("p0_imm", core_params[31:0], 32'd7);
        wr(24'd1, 32'd3);
        chk("p01", core_params[63:0], {32'd3, 32'd7});
        rd(24'd0);
        chk("rd_p0", output_value, 32'd7);
        chk("rd_p0_inr", in_range, 1);

        // start / run / done on core 0
        wr(24'd3, 32'd1);
        chk("start_pulse", core_start, 2'b01);
        cyc();
        chk("start_once", core_start, 2'b00);
        rd(24'd3);
        chk("st_busy", output_value, 32'd1);
        core_results = 64'h0000_0000_0000_000A;
        core_done    = 2'b01;
        cyc();
        core_done    = 2'b00;
        rd(24'd2);
        chk("res0", output_value, 32'hA);
        rd(24'd3);
        chk("st_valid", output_value, 32'd2);

        // busy-time protection and error handling
        core_results = 64'h0000_0000_0000_0055;
        wr(24'd3, 32'd1);
        rd(24'd3);
        chk("st_rerun", output_value, 32'd1);
        wr(24'd0, 32'd9);
        chk("p0_locked", core_params[31:0], 32'd7);
        rd(24'd3);
        chk("st_err", output_value, 32'd5);
        rd(24'd2);
        chk("res_hold", output_value, 32'hA);
        wr(24'd3, 32'd4);
        rd(24'd3);
        chk("st_clr", output_value, 32'd1);
        wr(24'd3, 32'd5);
        rd(24'd3);
        chk("set_wins", output_value, 32'd5);
        wr(24'd3, 32'd4);
        wr(24'd4, 32'h11);
        chk("p1_indep", core_params[95:64], 32'h11);

        // out-of-range read holds output
        rd(24'd8);
        chk("oor_hold", output_value, 32'd5);
        chk("oor_inr", in_range, 0);

        core_done = 2'b01;
        cyc();
        core_done = 2'b00;
        rd(24'd2);
        chk("res_new", output_value, 32'h55);
        rd(24'd3);
        chk("st_done", output_value, 32'd2);

        // auto-start instance: done in the pulse cycle is ignored
        auto_phase = 1'b1;
        wr(24'd5, 32'h22);
        chk("auto_pulse", core_start_a, 2'b10);
        chk("auto_param", core_params_a[127:96], 32'h22);
        core_results_a = 64'h0000_BEEF_0000_0000;
        core_done_a    = 2'b10;
        cyc();
        core_done_a    = 2'b00;
        chk("auto_once", core_start_a, 2'b00);
        rd(24'd7);
        chk("auto_busy", output_value_a, 32'd1);
        auto_phase = 1'b0;

        // reset in the middle of a run
        wr(24'd3, 32'd1);
        chk("pre_rst_pulse", core_start, 2'b01);
        cyc();
        reset = 1'b1;
        cyc();
        chk("mid_rst_start", core_start, 0);
        chk("mid_rst_params", core_params, 0);
        chk("mid_rst_out", output_value, 0);
        reset = 1'b0;
        core_done = 2'b01;
        cyc();
        core_done = 2'b00;
        chk("post_rst_start", core_start, 0);
        rd(24'd3);
        chk("post_rst_st", output_value, 32'd0);
        chk("post_rst_inr", in_range, 1);
        rd(24'd2);
        chk("post_rst_res", output_value, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/core_bank_interface.md
Name: core_bank_interface

Overview:
- Multi-core successor to the single-core parameter interface.
- Decodes TitanComms host instructions (NOP/WRITE/READ) over a shared address/value bus into a bank of NUM_CORES compute cores.
- Each core gets a parameter register file, a start/done run-control FSM, captured result registers and a status word.
- Sits between the comms decoder and the generated compute cores.

Parameters:
- NUM_CORES, 2, number of cores served.
- PARAMS_PER_CORE, 2, writable parameter words per core.
- RESULTS_PER_CORE, 1, result words per core.
- DATA_WIDTH, 32, width of value, parameter and result words.
- ADDR_WIDTH, 24, host address width.
- START_ADDRESS, 0, base address of core 0.
- CORE_STRIDE, 4, address span per core. Must be ≥ PARAMS_PER_CORE+RESULTS_PER_CORE+1; elaboration error otherwise.
- AUTO_START, 0, when 1 a write to the last parameter word also starts the core.

Ports:
- clock  input  1  system clock, all logic on rising edge.
- reset  input  1  synchronous, active-high.
- instruction  input  8  TitanComms::instructions code.
- address  input  ADDR_WIDTH  host address.
- value  input  DATA_WIDTH  write data.
- output_value  output  DATA_WIDTH  registered read data.
- in_range  output  1  registered; 1 when the previous-cycle address decoded into any core.
- core_params  output  NUM_CORES*PARAMS_PER_CORE*DATA_WIDTH  flattened parameters, core-major.
- core_start  output  NUM_CORES  one-cycle start pulse per core.
- core_done  input  NUM_CORES  per-core completion pulse/level.
- core_results  input  NUM_CORES*RESULTS_PER_CORE*DATA_WIDTH  flattened live core outputs.

Behaviour:
- Address map for core c:
  - base = START_ADDRESS + c*CORE_STRIDE.
  - Offsets 0..P-1: parameters (R/W).
  - Offsets P..P+R-1: results (R).
  - Offset P+R: status (R/W).
  - Remaining offsets up to CORE_STRIDE-1: in range, reads return 0, writes ignored.
  - Addresses outside every core: in_range=0, no side effects.
- Status read format: bit0 busy, bit1 result_valid, bit2 error (sticky). Upper bits 0.
- Status write:
  - value bit0=1 requests start.
  - value bit2=1 clears error.
  - Both may be set together.
- Reset values:
  - output_value=0, in_range=0, core_start=0.
  - All parameters and result registers 0.
  - Every FSM in IDLE; status=0.
- Read latency: 1 cycle. output_value updates on the edge after READ is presented. It holds its last value on NOP, WRITE, or an out-of-range READ.
- Parameter WRITE takes effect on the next edge and is visible on core_params the same edge.
- Per-core FSM states: IDLE, RUN, DONE.
  - IDLE/DONE → RUN on a start request (status write bit0, or AUTO_START with a write to offset P-1). core_start[c]=1 for exactly the first RUN cycle. result_valid clears on entry.
  - RUN: core_done[c] is ignored in the cycle core_start[c] is high. On any later cycle with core_done[c]=1, capture all R result words from core_results, set result_valid=1, go to DONE.
  - core_done in IDLE/DONE: ignored.
- busy = (state==RUN).
- While busy:
  - Parameter writes are dropped and set error.
  - A start request is dropped and sets error.
  - Reads are always allowed. Result reads return the last captured values.
- Simultaneous error-clear and error-setting event in one cycle: set wins.
- Reset asserted mid-RUN: FSM returns to IDLE next edge and no pulse is issued. A late core_done is ignored.
- Cores are independent. Only one host access per cycle exists, but FSMs for different cores advance concurrently.
- Widths: offset = address − base, computed in ADDR_WIDTH bits. Core index = offset / CORE_STRIDE, checked against NUM_CORES. No wrap-around: an address below START_ADDRESS is out of range.

Decomposition:
- TitanComms package:
  - Existing instructions enum.
  - New STATUS_BUSY_BIT, STATUS_VALID_BIT, STATUS_ERROR_BIT constants.
  - core_state_t enum {IDLE, RUN, DONE}.
- Sub-module core_channel: one core's parameter registers, FSM, result capture and status. Generated NUM_CORES times.
- Top level: address decode and read mux only.

Test Plan:
- Write 7 → addr 0 and 3 → addr 1 (defaults), then READ addr 0 → output_value=7 one cycle later, in_range=1. core_params[31:0]=7, [63:32]=3.
- WRITE 1 → addr 3 (core 0 status) → core_start[0] pulses 1 cycle. READ addr 3 → 1 (busy). Drive core_done[0] with core_results=0xA → READ addr 2 → 0xA. READ addr 3 → 2.
- While core 0 busy, WRITE 9 → addr 0 → param stays 7, status reads 0x5. WRITE 4 → addr 3 → status 0x1.
- READ addr 8 (beyond NUM_CORES*CORE_STRIDE) → in_range=0, output_value unchanged.
- AUTO_START=1: WRITE → addr 5 (core 1 last param) → core_start[1] pulses. core_done[1] asserted in the same cycle as the pulse is ignored and busy stays 1.
- Assert reset during RUN → status 0, core_params 0, no core_start. A subsequent core_done leaves result_valid=0.
